timer_arbiter: RTL

- Shares one one-shot timer window between NREQ requesters.
- Round-robin arbitration grants one requester at a time and runs an OUT window of that requester's programmed length.
- Signals completion per requester and inserts a programmable idle gap between windows.
- Sits between the trigger-generating logic and the single shared pulse/gate output of the timing datapath.

---
 rtl/timer_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin sharing of one one-shot timer window between NREQ requesters.
// Optional macro TIMER_ARBITER_RETRIG_EN adds per-requester window restart via RETRIG.
`default_nettype none

module timer_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 8,
    parameter int GAP  = 2
) (
    input  logic                 CLK,
    input  logic                 R,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ*CW-1:0]   LEN,
    input  logic                 ABORT,
    input  logic [NREQ-1:0]      RETRIG,
    output logic [NREQ-1:0]      GNT,
    output logic                 OUT,
    output logic [NREQ-1:0]      DONE,
    output logic                 ABORTED,
    output logic                 BUSY
);

    localparam int             IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0]  PTR_RST  = IW'(NREQ - 1);
    localparam logic [CW-1:0]  GAP_LOAD = (GAP > 0) ? CW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            out_q, out_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            aborted_q, aborted_d;
    logic            busy_q, busy_d;

    logic            found;
    logic [IW-1:0]   sel;
    logic [CW-1:0]   len_sel;
    logic            finish;
    int              idx;

    // Rotating priority search starting just after the last granted index
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && REQ[idx[IW-1:0]]) begin
                found = 1'b1;
                sel   = idx[IW-1:0];
            end
        end
    end

    assign len_sel = LEN[sel*CW +: CW];

`ifdef TIMER_ARBITER_RETRIG_EN
    logic [CW-1:0] len_cur;
    logic          retrig_hit;
    assign len_cur    = LEN[ptr_q*CW +: CW];
    assign retrig_hit = |(RETRIG & gnt_q);
`else
    logic unused_retrig;
    assign unused_retrig = ^RETRIG;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        out_d     = out_q;
        done_d    = '0;
        aborted_d = 1'b0;
        finish    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d    = S_RUN;
                    gnt_d      = '0;
                    gnt_d[sel] = 1'b1;
                    out_d      = 1'b1;
                    cnt_d      = len_sel - CW'(1);
                    ptr_d      = sel;
                end
            end
            S_RUN: begin
                if (ABORT) begin
                    finish    = 1'b1;
                    aborted_d = 1'b1;
                end
`ifdef TIMER_ARBITER_RETRIG_EN
                else if (retrig_hit) begin
                    cnt_d = len_cur - CW'(1);
                end
`endif
                else if (cnt_q == '0) begin
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                // The DONE cycle already counts as the first gap cycle
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                gnt_d   = '0;
                out_d   = 1'b0;
            end
        endcase

        if (finish) begin
            gnt_d  = '0;
            out_d  = 1'b0;
            done_d = gnt_q;
            if (GAP > 0) begin
                state_d = S_GAP;
                cnt_d   = GAP_LOAD;
            end else begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ptr_q     <= PTR_RST;
            gnt_q     <= '0;
            out_q     <= 1'b0;
            done_q    <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            out_q     <= out_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
        end
    end

    assign GNT     = gnt_q;
    assign OUT     = out_q;
    assign DONE    = done_q;
    assign ABORTED = aborted_q;
    assign BUSY    = busy_q;

endmodule

`default_nettype wire
